dmem_resp: RTL



---
 rtl/dmem_resp_pkg.sv | 45 ++++
 rtl/dmem_resp_ram.sv | 41 ++++
 rtl/dmem_resp.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_resp_pkg.sv
// ----------------------------------------------------------------------------
// configure / dmem_resp_wires : shared request/response types and the
// responder's state encoding and request-register layout.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package configure;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

package dmem_resp_wires;

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_WAIT = 2'd1;
  localparam logic [1:0] C_ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_WAIT = C_ST_WAIT,
    ST_RESP = C_ST_RESP
  } state_t;

  // What the response cycle needs to know about the accepted request
  typedef struct packed {
    logic fence;
    logic hit;
  } req_reg_t;

endpackage

`default_nettype wire

// File: rtl/dmem_resp_ram.sv
// ----------------------------------------------------------------------------
// dmem_resp_ram : single-port synchronous RAM, 2**DEPTH x 32, byte write
// enables, registered read data with write-first behaviour.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_resp_ram #(
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [DEPTH-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int C_WORDS = 2 ** DEPTH;

  // One byte-wide bank per lane so every bank has exactly one writer
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_bank [C_WORDS];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[i]) begin
          r_bank[addr] <= wdata[8*i +: 8];
          r_q          <= wdata[8*i +: 8];
        end else begin
          r_q          <= r_bank[addr];
        end
      end
    end

    assign rdata[8*i +: 8] = r_q;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_resp.sv
// ----------------------------------------------------------------------------
// dmem_resp : memory-side responder / main-memory model for the
// mem_in_type/mem_out_type interface with programmable response latency.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_resp
  import configure::*;
  import dmem_resp_wires::*;
#(
  parameter int          MEM_DEPTH     = 12,
  parameter int          MEM_LATENCY   = 2,
  parameter logic [31:0] MEM_BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out
);

  localparam logic [3:0] C_LAT_M1 = 4'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_ready;
  req_reg_t       r_req;

  logic [31:0]          w_offset;
  logic                 w_hit;
  logic [MEM_DEPTH-1:0] w_index;
  logic                 w_accept;
  logic                 w_ram_en;
  logic [31:0]          w_ram_rdata;
  logic                 w_unused_ok;

  assign w_offset = mem_in.mem_addr - MEM_BASE_ADDR;
  assign w_hit    = (w_offset[31:MEM_DEPTH+2] == '0);
  assign w_index  = w_offset[MEM_DEPTH+1:2];
  assign w_accept = rst && (r_state == ST_IDLE) && mem_in.mem_valid;
  // The array is touched only on the accept edge, so its read register
  // holds the response word untouched through the wait cycles.
  assign w_ram_en = w_accept && !mem_in.mem_fence && w_hit;

  assign w_unused_ok = ^{mem_in.mem_instr, w_offset[1:0]};

  dmem_resp_ram #(
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (mem_in.mem_wstrb),
    .addr  (w_index),
    .wdata (mem_in.mem_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_req   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (mem_in.mem_valid) begin
            r_req.fence <= mem_in.mem_fence;
            r_req.hit   <= w_hit;
            if (MEM_LATENCY == 0) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= C_LAT_M1;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_out.mem_ready = r_ready;
  assign mem_out.mem_rdata = (r_ready && r_req.hit && !r_req.fence) ? w_ram_rdata : 32'h0;

endmodule

`default_nettype wire
